io_arbiter: RTL and testbench

Two-requester arbiter that shares the single memory-mapped I/O port (seven-segment output registers and switch readback) between the CPU load/store path (requester 0) and a secondary master such as a debug/refresh engine (requester 1). It serialises accesses with a round-robin grant and drives the port's addr/write-enable/data lines. It also captures the port's registered read data one cycle after issue and returns it to the owning requester with a completion pulse.

---
 rtl/io_arbiter.sv | 142 ++++++++++++++
 tb/tb_io_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_arbiter.sv
// rtl/io_arbiter.sv - two-requester round-robin arbiter for the memory-mapped I/O port
module io_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              i_clock,
  input  logic              i_resetn,
  // requester 0 (CPU load/store path)
  input  logic              i_req0,
  input  logic              i_we0,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [DATA_W-1:0] i_wdata0,
  output logic              o_gnt0,
  output logic              o_done0,
  output logic [DATA_W-1:0] o_rdata0,
  // requester 1 (secondary master)
  input  logic              i_req1,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_gnt1,
  output logic              o_done1,
  output logic [DATA_W-1:0] o_rdata1,
  // status
  output logic              o_busy,
  // shared I/O port
  output logic [ADDR_W-1:0] o_io_addr,
  output logic              o_io_we,
  output logic [DATA_W-1:0] o_io_wdata,
  input  logic [DATA_W-1:0] i_io_rdata
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_owner;
  logic                r_last_owner;
  logic                r_gnt0;
  logic                r_gnt1;
  logic                r_done0;
  logic                r_done1;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;
  logic                r_busy;
  logic [ADDR_W-1:0]   r_io_addr;
  logic                r_io_we;
  logic [DATA_W-1:0]   r_io_wdata;

  logic                w_any_req;
  logic                w_pick1;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_sel_we;

  // Winner selection: a lone requester wins; on a tie the one that did not
  // own the port last time wins, so sustained dual traffic alternates.
  always_comb begin
    w_any_req   = i_req0 | i_req1;
    w_pick1     = i_req1 & (~i_req0 | ~r_last_owner);
    w_sel_addr  = w_pick1 ? i_addr1  : i_addr0;
    w_sel_wdata = w_pick1 ? i_wdata1 : i_wdata0;
    w_sel_we    = w_pick1 ? i_we1    : i_we0;
  end

  // Arbitration FSM: IDLE samples requests, ACCESS presents the access to the
  // port for one cycle, CAPTURE picks up the port's registered read data.
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
      r_busy       <= 1'b0;
      r_io_addr    <= '0;
      r_io_we      <= 1'b0;
      r_io_wdata   <= '0;
    end else begin
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_io_addr    <= w_sel_addr;
            r_io_wdata   <= w_sel_wdata;
            r_io_we      <= w_sel_we;
            r_gnt0       <= ~w_pick1;
            r_gnt1       <= w_pick1;
            r_owner      <= w_pick1;
            r_last_owner <= w_pick1;
            r_busy       <= 1'b1;
            r_state      <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // The port latches the write at this edge; address/data stay put so
          // the registered readback in CAPTURE refers to the same location.
          r_io_we <= 1'b0;
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (r_owner) begin
            r_rdata1 <= i_io_rdata;
            r_done1  <= 1'b1;
          end else begin
            r_rdata0 <= i_io_rdata;
            r_done0  <= 1'b1;
          end
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_io_we <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_gnt0     = r_gnt0;
  assign o_gnt1     = r_gnt1;
  assign o_done0    = r_done0;
  assign o_done1    = r_done1;
  assign o_rdata0   = r_rdata0;
  assign o_rdata1   = r_rdata1;
  assign o_busy     = r_busy;
  assign o_io_addr  = r_io_addr;
  assign o_io_we    = r_io_we;
  assign o_io_wdata = r_io_wdata;

endmodule

// File: tb/tb_io_arbiter.sv
// tb/tb_io_arbiter.sv - directed-vector bench for io_arbiter
module tb_io_arbiter;

  logic        clk;
  logic        resetn;
  logic        req0, req1, we0, we1;
  logic [4:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, busy;
  logic [31:0] rdata0, rdata1;
  logic [4:0]  io_addr;
  logic        io_we;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;

  int n_vec = 0;
  int n_err = 0;
  int we_cycles = 0;

  // I/O port model: switches are fixed, writes land in HEX pair registers.
  logic [9:0]  sw = 10'h2A5;
  logic [7:0]  hex [8];

  io_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .i_clock   (clk),
    .i_resetn  (resetn),
    .i_req0    (req0),
    .i_we0     (we0),
    .i_addr0   (addr0),
    .i_wdata0  (wdata0),
    .o_gnt0    (gnt0),
    .o_done0   (done0),
    .o_rdata0  (rdata0),
    .i_req1    (req1),
    .i_we1     (we1),
    .i_addr1   (addr1),
    .i_wdata1  (wdata1),
    .o_gnt1    (gnt1),
    .o_done1   (done1),
    .o_rdata1  (rdata1),
    .o_busy    (busy),
    .o_io_addr (io_addr),
    .o_io_we   (io_we),
    .o_io_wdata(io_wdata),
    .i_io_rdata(io_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] port_rd(input logic [4:0] a);
    case (a)
      5'd0:    port_rd = {28'b0, sw[3:0]};
      5'd1:    port_rd = {28'b0, sw[7:4]};
      5'd2:    port_rd = {30'b0, sw[9:8]};
      default: port_rd = 32'h0;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) hex[i] = 8'h00;
    io_rdata = 32'h0;
  end

  always @(posedge clk) begin
    if (io_we) hex[io_addr[2:0]] <= io_wdata[7:0];
    io_rdata <= port_rd(io_addr);
  end

  always @(negedge clk) if (io_we) we_cycles++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cyc();
    cyc();
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;

    // reset state
    cyc();
    cyc();
    check("rst_gnt",   32'({gnt1, gnt0}), 32'd0);
    check("rst_done",  32'({done1, done0}), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_io_we", 32'(io_we), 32'd0);
    check("rst_addr",  32'(io_addr), 32'd0);
    check("rst_wdata", io_wdata, 32'd0);
    check("rst_rd0",   rdata0, 32'd0);
    check("rst_rd1",   rdata1, 32'd0);
    resetn = 1'b1;

    // single read by requester 0
    req0 = 1; we0 = 0; addr0 = 5'd1;
    cyc();
    check("rd_gnt0",   32'(gnt0), 32'd1);
    check("rd_gnt1",   32'(gnt1), 32'd0);
    check("rd_ioaddr", 32'(io_addr), 32'd1);
    check("rd_iowe",   32'(io_we), 32'd0);
    check("rd_busy1",  32'(busy), 32'd1);
    req0 = 0;
    cyc();
    check("rd_gnt_off", 32'(gnt0), 32'd0);
    check("rd_busy2",   32'(busy), 32'd1);
    check("rd_nodone",  32'(done0), 32'd0);
    cyc();
    check("rd_done0",  32'(done0), 32'd1);
    check("rd_done1",  32'(done1), 32'd0);
    check("rd_rdata0", rdata0, 32'h0000000A);
    check("rd_rdata1", rdata1, 32'd0);
    check("rd_busy3",  32'(busy), 32'd0);
    cyc();
    check("rd_done_off", 32'(done0), 32'd0);

    // single write by requester 1
    we_cycles = 0;
    req1 = 1; we1 = 1; addr1 = 5'd0; wdata1 = 32'h37;
    cyc();
    check("wr_gnt1",   32'(gnt1), 32'd1);
    check("wr_iowe",   32'(io_we), 32'd1);
    check("wr_wdata",  io_wdata, 32'h37);
    req1 = 0; we1 = 0;
    cyc();
    check("wr_iowe_off", 32'(io_we), 32'd0);
    cyc();
    check("wr_done1",  32'(done1), 32'd1);
    check("wr_done0",  32'(done0), 32'd0);
    check("wr_rdata1", rdata1, 32'h5);
    check("wr_rdata0", rdata0, 32'h0000000A);
    check("wr_hex0",   32'(hex[0]), 32'h37);
    check("wr_wecnt",  32'(we_cycles), 32'd1);

    // tie after reset: grants alternate 0,1,0,1 three cycles apart
    do_reset();
    req0 = 1; we0 = 0; addr0 = 5'd2;
    req1 = 1; we1 = 0; addr1 = 5'd1;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      check($sformatf("tie_g0_c%0d", c), 32'(gnt0),  32'(c == 1 || c == 7));
      check($sformatf("tie_g1_c%0d", c), 32'(gnt1),  32'(c == 4 || c == 10));
      check($sformatf("tie_d0_c%0d", c), 32'(done0), 32'(c == 3 || c == 9));
      check($sformatf("tie_d1_c%0d", c), 32'(done1), 32'(c == 6 || c == 12));
      if (c == 3) check("tie_rdata0", rdata0, 32'h2);
      if (c == 6) check("tie_rdata1", rdata1, 32'hA);
      if (c == 12) begin req0 = 0; req1 = 0; end
    end
    cyc();
    check("tie_idle", 32'({gnt1, gnt0, busy}), 32'd0);

    // back-to-back reads by requester 0 to addr 0,1,2
    req0 = 1; we0 = 0; addr0 = 5'd0;
    begin
      int ngnt = 0;
      for (int c = 1; c <= 9; c++) begin
        cyc();
        check($sformatf("b2b_g0_c%0d", c), 32'(gnt0),  32'(c == 1 || c == 4 || c == 7));
        check($sformatf("b2b_d0_c%0d", c), 32'(done0), 32'(c == 3 || c == 6 || c == 9));
        if (c == 3) check("b2b_rd_a0", rdata0, 32'h5);
        if (c == 6) check("b2b_rd_a1", rdata0, 32'hA);
        if (c == 9) check("b2b_rd_a2", rdata0, 32'h2);
        if (gnt0) begin
          ngnt++;
          addr0 = 5'(ngnt);
          if (ngnt == 3) req0 = 0;
        end
      end
    end
    cyc();
    check("b2b_idle", 32'({gnt0, busy}), 32'd0);

    // late arrival: req1 raised while requester 0 is in ACCESS
    req0 = 1; we0 = 0; addr0 = 5'd1;
    cyc();
    check("late_gnt0", 32'(gnt0), 32'd1);
    req0 = 0;
    req1 = 1; we1 = 0; addr1 = 5'd2;
    cyc();
    check("late_nog1_c2", 32'(gnt1), 32'd0);
    cyc();
    check("late_done0", 32'(done0), 32'd1);
    check("late_nog1_c3", 32'(gnt1), 32'd0);
    cyc();
    check("late_gnt1", 32'(gnt1), 32'd1);
    req1 = 0;
    cyc();
    cyc();
    check("late_done1", 32'(done1), 32'd1);
    check("late_rdata1", rdata1, 32'h2);
    check("late_rdata0", rdata0, 32'hA);

    // reset asserted mid-ACCESS of a write
    cyc();
    req0 = 1; we0 = 1; addr0 = 5'd3; wdata0 = 32'hFF;
    cyc();
    check("mid_iowe_on", 32'(io_we), 32'd1);
    req0 = 0; we0 = 0;
    #2 resetn = 1'b0;
    #1;
    check("mid_iowe_off", 32'(io_we), 32'd0);
    check("mid_gnt0",     32'(gnt0), 32'd0);
    check("mid_busy",     32'(busy), 32'd0);
    check("mid_ioaddr",   32'(io_addr), 32'd0);
    check("mid_iowdata",  io_wdata, 32'd0);
    check("mid_rdata",    rdata0 | rdata1, 32'd0);
    cyc();
    cyc();
    resetn = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      check($sformatf("mid_nodone_c%0d", c), 32'({done1, done0}), 32'd0);
      check($sformatf("mid_busy_c%0d", c),   32'(busy), 32'd0);
    end
    check("mid_hex3", 32'(hex[3]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
